// File: rtl/tof_pkg.sv
// Shared types and defaults for the ultrasonic time-of-flight ping controller.
package tof_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEmit,
    StBlank,
    StListen,
    StHoldoff
  } tof_state_e;

  localparam int unsigned DefCarrierHalf  = 1250;
  localparam int unsigned DefBurstPulses  = 8;
  localparam int unsigned DefBlankCycles  = 100000;
  localparam int unsigned DefTimeoutCycles = 2500000;
  localparam int unsigned DefHoldoffCycles = 1000000;
  localparam int unsigned DebounceLen     = 4;

  localparam logic [31:0] CountMax = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CountMax) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tof_carrier_gen.sv
// Transducer carrier burst: starts high, toggles every CARRIER_HALF cycles while enabled,
// flags the final cycle of a BURST_PULSES-period burst. Counters clear whenever disabled.
module tof_carrier_gen
  import tof_pkg::*;
#(
  parameter int unsigned CARRIER_HALF = DefCarrierHalf,
  parameter int unsigned BURST_PULSES = DefBurstPulses
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  output logic carrier_out,
  output logic done_out
);

  localparam logic [31:0] HalfLast   = 32'(CARRIER_HALF - 1);
  localparam logic [31:0] HalvesLast = 32'(2 * BURST_PULSES - 1);

  logic [31:0] half_cnt_q, half_cnt_d;
  logic [31:0] halves_q, halves_d;
  logic        phase_q, phase_d;
  logic        half_end;

  always_comb begin
    half_end   = en_in && (half_cnt_q == HalfLast);
    half_cnt_d = half_cnt_q;
    halves_d   = halves_q;
    phase_d    = phase_q;
    if (!en_in) begin
      half_cnt_d = '0;
      halves_d   = '0;
      phase_d    = 1'b0;
    end else if (half_end) begin
      half_cnt_d = '0;
      halves_d   = halves_q + 32'd1;
      phase_d    = ~phase_q;
    end else begin
      half_cnt_d = half_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      half_cnt_q <= '0;
      halves_q   <= '0;
      phase_q    <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      halves_q   <= halves_d;
      phase_q    <= phase_d;
    end
  end

  // Gated by enable so the drive drops with the state register, including on async reset.
  assign carrier_out = en_in & ~phase_q;
  assign done_out    = half_end && (halves_q == HalvesLast);

endmodule

// File: rtl/tof_ping_controller.sv
// Ping sequencer: emit burst, blank, listen for echo or timeout, hold off, repeat.
// Optional ECHO_DEBOUNCE_EN requires a run of DebounceLen high echo samples.
module tof_ping_controller
  import tof_pkg::*;
#(
  parameter int unsigned CARRIER_HALF   = DefCarrierHalf,
  parameter int unsigned BURST_PULSES   = DefBurstPulses,
  parameter int unsigned BLANK_CYCLES   = DefBlankCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned HOLDOFF_CYCLES = DefHoldoffCycles
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        repeat_in,
  input  logic        echo_in,
  output logic        emit_out,
  output logic [31:0] time_since_emission_out,
  output logic        echo_out,
  output logic        timeout_out,
  output logic        busy_out
);

  localparam logic [31:0] BlankLast = 32'(BLANK_CYCLES - 1);
  localparam logic [31:0] TimeoutAt = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HoldLast  = 32'(HOLDOFF_CYCLES - 1);

  tof_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        echo_q, echo_d;
  logic        tmo_q, tmo_d;
  logic        carrier, emit_done;
  logic        echo_accept;
  logic [31:0] echo_count;

  tof_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF),
    .BURST_PULSES(BURST_PULSES)
  ) u_carrier (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_in      (state_q == StEmit),
    .carrier_out(carrier),
    .done_out   (emit_done)
  );

`ifdef ECHO_DEBOUNCE_EN
  localparam logic [2:0] RunLast = 3'(DebounceLen - 1);

  logic [2:0]  run_q, run_d;
  logic [31:0] first_q, first_d;

  // Frozen count is the first sample of the qualifying run, not the accepting one.
  always_comb begin
    run_d       = '0;
    first_d     = first_q;
    echo_accept = 1'b0;
    echo_count  = first_q;
    if (state_q == StListen && echo_in) begin
      if (run_q == '0) begin
        first_d    = cnt_q;
        echo_count = cnt_q;
      end
      if (run_q == RunLast) echo_accept = 1'b1;
      else run_d = run_q + 3'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_q   <= '0;
      first_q <= '0;
    end else begin
      run_q   <= run_d;
      first_q <= first_d;
    end
  end
`else
  assign echo_accept = (state_q == StListen) && echo_in;
  assign echo_count  = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = '0;
    echo_d  = echo_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in || repeat_in) begin
          state_d = StEmit;
          cnt_d   = '0;
          echo_d  = 1'b0;
        end
      end
      StEmit: begin
        cnt_d = sat_inc(cnt_q);
        if (emit_done) state_d = StBlank;
      end
      StBlank: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q >= BlankLast) state_d = StListen;
      end
      StListen: begin
        // Echo wins over timeout when both land on the same cycle.
        if (echo_accept) begin
          state_d = StHoldoff;
          cnt_d   = echo_count;
          echo_d  = 1'b1;
        end else if (cnt_q >= TimeoutAt) begin
          state_d = StHoldoff;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      StHoldoff: begin
        hold_d = hold_q + 32'd1;
        if (hold_q >= HoldLast) begin
          hold_d = '0;
          if (repeat_in) begin
            state_d = StEmit;
            cnt_d   = '0;
            echo_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
      echo_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      echo_q  <= echo_d;
      tmo_q   <= tmo_d;
    end
  end

  assign emit_out                = carrier;
  assign time_since_emission_out = cnt_q;
  assign echo_out                = echo_q;
  assign timeout_out             = tmo_q;
  assign busy_out                = (state_q != StIdle);

endmodule

// File: tb/tb_tof_ping_controller.sv
// Randomised bench for tof_ping_controller with a ping-level echo/timeout reference model.
module tb_tof_ping_controller;

  localparam int unsigned CH       = 2;
  localparam int unsigned BP       = 2;
  localparam int unsigned BLANK    = 10;
  localparam int unsigned TMO      = 100;
  localparam int unsigned HOLD     = 20;
  localparam int unsigned EMIT_LEN = 2 * CH * BP;
`ifdef ECHO_DEBOUNCE_EN
  localparam int unsigned DB = 4;
`else
  localparam int unsigned DB = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start, rep, echo;
  logic        emit, echo_o, tmo_o, busy;
  logic [31:0] tse;

  int checks = 0;
  int errors = 0;
  bit pat [0:127];

  always #5 clk = ~clk;

  tof_ping_controller #(
    .CARRIER_HALF  (CH),
    .BURST_PULSES  (BP),
    .BLANK_CYCLES  (BLANK),
    .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk_in                 (clk),
    .rst_in                 (rst),
    .start_in               (start),
    .repeat_in              (rep),
    .echo_in                (echo),
    .emit_out               (emit),
    .time_since_emission_out(tse),
    .echo_out               (echo_o),
    .timeout_out            (tmo_o),
    .busy_out               (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 128; i++) pat[i] = 1'b0;
  endtask

  task automatic set_run(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i <= hi && i < 128; i++) pat[i] = 1'b1;
  endtask

  task automatic random_pat();
    int unsigned mode, lo;
    clear_pat();
    mode = $urandom_range(0, 3);
    case (mode)
      1: begin
        lo = $urandom_range(0, 110);
        set_run(lo, lo + $urandom_range(0, 7));
      end
      2: for (int i = 0; i < 128; i++) pat[i] = ($urandom_range(0, 9) < 3);
      3: begin
        lo = $urandom_range(0, 1) ? $urandom_range(BLANK - 4, BLANK + 2)
                                  : $urandom_range(TMO - 5, TMO + 1);
        set_run(lo, lo + $urandom_range(0, 5));
      end
      default: ;
    endcase
  endtask

  // Acceptance rule: first run of DB consecutive highs sampled within counts [BLANK, TMO].
  task automatic predict(output bit hit, output int unsigned first, output int unsigned last);
    int unsigned run;
    run   = 0;
    hit   = 1'b0;
    first = 0;
    last  = TMO;
    for (int unsigned k = BLANK; k <= TMO; k++) begin
      run = pat[k] ? run + 1 : 0;
      if (!hit && run == DB) begin
        hit   = 1'b1;
        first = k - DB + 1;
        last  = k;
      end
    end
  endtask

  // Entered #1 after the edge that moved the DUT into EMIT (count 0).
  task automatic ping_body();
    bit          hit;
    int unsigned first, last, frozen;
    predict(hit, first, last);
    frozen = hit ? first : TMO;
    check_eq("emit_start_echo_clear", 32'(echo_o), 0);
    check_eq("emit_busy", 32'(busy), 1);
    for (int unsigned k = 0; k <= last; k++) begin
      echo = pat[k];
      if (k < EMIT_LEN) check_eq("emit_pattern", 32'(emit), 32'((k / CH) % 2 == 0));
      else check_eq("emit_idle_low", 32'(emit), 0);
      if (k == 0 || k == EMIT_LEN - 1 || k == BLANK || k == last)
        check_eq("count", tse, 32'(k));
      if (k == last) begin
        check_eq("echo_before_accept", 32'(echo_o), 0);
        check_eq("timeout_early", 32'(tmo_o), 0);
      end
      @(posedge clk); #1;
    end
    echo = 1'b0;
    check_eq("frozen_count", tse, 32'(frozen));
    check_eq("echo_out", 32'(echo_o), 32'(hit));
    check_eq("timeout_pulse", 32'(tmo_o), 32'(!hit));
    for (int unsigned h = 1; h < HOLD; h++) begin
      start = (h == 5) && !rep;
      @(posedge clk); #1;
      if (h == 1) check_eq("timeout_single", 32'(tmo_o), 0);
      if (h == HOLD - 1) begin
        check_eq("holdoff_busy", 32'(busy), 1);
        check_eq("holdoff_count", tse, 32'(frozen));
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    if (rep) begin
      check_eq("repeat_emit", 32'(emit), 1);
      check_eq("repeat_count", tse, 0);
      check_eq("repeat_echo_clear", 32'(echo_o), 0);
    end else begin
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_echo_held", 32'(echo_o), 32'(hit));
      check_eq("idle_count_held", tse, 32'(frozen));
      repeat (2) @(posedge clk);
      #1;
      check_eq("start_not_queued", 32'(busy), 0);
    end
  endtask

  task automatic one_shot();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ping_body();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_emit"}, 32'(emit), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_count"}, tse, 0);
    check_eq({tag, "_echo"}, 32'(echo_o), 0);
    check_eq({tag, "_timeout"}, 32'(tmo_o), 0);
  endtask

  task automatic reset_mid_emit(input int unsigned at);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (at) @(posedge clk);
    #1;
    check_eq("pre_reset_count", tse, 32'(at));
    check_eq("pre_reset_emit", 32'(emit), 32'((at / CH) % 2 == 0));
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_auto_ping", 32'(busy), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rep   = 1'b0;
    echo  = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_after_reset", 32'(busy), 0);

    clear_pat(); pat[50] = 1'b1;
    one_shot();
    clear_pat(); pat[5] = 1'b1;
    one_shot();
    clear_pat(); pat[5] = 1'b1; pat[100] = 1'b1;
    one_shot();
    clear_pat(); set_run(97, 100);
    one_shot();
    clear_pat(); set_run(40, 42); set_run(60, 63);
    one_shot();
    for (int i = 0; i < 8; i++) begin
      random_pat();
      one_shot();
    end

    rep = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      random_pat();
      if (i == 2) rep = 1'b0;
      ping_body();
    end

    clear_pat(); set_run(30, 40);
    one_shot();
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_idle");
    @(posedge clk); #1;
    rst = 1'b0;
    reset_mid_emit(1);
    reset_mid_emit(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tof_ping_controller.md
TOF_PING_CONTROLLER -- requirements
Module: tof_ping_controller

Interface
REQ-001 SHALL have parameter CARRIER_HALF, 1250, transducer carrier half-period in clk_in cycles (40 kHz at 100 MHz).
REQ-002 SHALL have parameter BURST_PULSES, 8, carrier periods per ping.
REQ-003 SHALL have parameter BLANK_CYCLES, 100000, echo-ignore window measured from emission start; must be at least 2*CARRIER_HALF*BURST_PULSES.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 2500000, emission-relative count at which a missing echo is declared.
REQ-005 SHALL have parameter HOLDOFF_CYCLES, 1000000, quiet interval after each ping.
REQ-006 SHALL have port clk_in, input, 1, single system clock; all logic SHALL be on its rising edge.
REQ-007 SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port start_in, input, 1, one-shot ping request.
REQ-009 SHALL have port repeat_in, input, 1, continuous ping mode.
REQ-010 SHALL have port echo_in, input, 1, receive comparator, already synchronised.
REQ-011 SHALL have port emit_out, output, 1, transducer drive carrier.
REQ-012 SHALL have port time_since_emission_out, output, 32, cycles since emission start; feeds the ToF range calculator.
REQ-013 SHALL have port echo_out, output, 1, echo-captured level to the ToF range calculator.
REQ-014 SHALL have port timeout_out, output, 1, one-cycle no-echo pulse.
REQ-015 SHALL have port busy_out, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, EMIT, BLANK, LISTEN, HOLDOFF.
REQ-017 IDLE SHALL move to EMIT on the next cycle when start_in or repeat_in is high; start_in outside IDLE SHALL be ignored, not queued.
REQ-018 The counter SHALL read 0 in the first EMIT cycle, increment by 1 each cycle through EMIT, BLANK and LISTEN, and saturate at 32'hFFFFFFFF.
REQ-019 EMIT SHALL last exactly 2*CARRIER_HALF*BURST_PULSES cycles; emit_out SHALL start high and toggle every CARRIER_HALF cycles; emit_out SHALL be 0 in every other state.
REQ-020 BLANK SHALL move to LISTEN when the counter reaches BLANK_CYCLES-1; echo_in SHALL be ignored in EMIT and BLANK.
REQ-021 In LISTEN, an accepted echo SHALL freeze time_since_emission_out at the counter value of the first high sample, assert echo_out on the following cycle, and enter HOLDOFF.
REQ-022 echo_out SHALL remain high, and the frozen count stable, until the next entry to EMIT.
REQ-023 If no echo is accepted, timeout_out SHALL pulse for one cycle when the counter equals TIMEOUT_CYCLES, and the state SHALL enter HOLDOFF.
REQ-024 When an echo is accepted on the timeout cycle, the echo SHALL take priority and timeout_out SHALL stay 0.
REQ-025 HOLDOFF SHALL last HOLDOFF_CYCLES cycles and then enter EMIT if repeat_in is high, else IDLE.
REQ-026 time_since_emission_out SHALL hold its last value in HOLDOFF and IDLE.

Reset
REQ-027 While rst_in is high, the state SHALL be IDLE and all outputs and counters SHALL be 0, asynchronously, including mid-burst.
REQ-028 The first ping after reset deassertion SHALL require start_in or repeat_in.

Configuration
REQ-029 With ECHO_DEBOUNCE_EN defined, an echo SHALL be accepted only after 4 consecutive high echo_in samples in LISTEN; the frozen value SHALL be the count of the first of those samples, and a low sample SHALL restart the run.
REQ-030 Without ECHO_DEBOUNCE_EN, the first high echo_in sample in LISTEN SHALL be accepted.

Structure
REQ-031 A shared package tof_pkg SHALL hold the state enum typedef, the default parameter constants, and the debounce length constant 4.
REQ-032 Carrier generation SHALL be a sub-module tof_carrier_gen with enable input, half-period counter, and pulse count done output.

Verification
Bench parameters: CARRIER_HALF=2, BURST_PULSES=2, BLANK_CYCLES=10, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=20.
REQ-033 One-shot: start_in pulse -> emit_out pattern 1,1,0,0,1,1,0,0 over 8 cycles, count 0..7; then BLANK, then LISTEN.
REQ-034 Echo: echo_in high when count=50 -> time_since_emission_out=50 frozen, echo_out high next cycle, then 20 HOLDOFF cycles, then IDLE with echo_out still high.
REQ-035 Timeout: no echo -> timeout_out single pulse at count=100, echo_out=0; echo_in asserted at count=5 ignored; echo_in asserted at count=100 -> echo_out high, no timeout pulse.
REQ-036 Repeat: repeat_in held high -> back-to-back pings, EMIT re-entered exactly 20 cycles after each HOLDOFF entry, echo_out cleared at each EMIT.
REQ-037 Reset at count=3 during EMIT -> emit_out=0 with no clock edge, state IDLE, outputs 0.
REQ-038 With ECHO_DEBOUNCE_EN: echo_in high at counts 40-42, low at 43, high at 60-63 -> frozen value 60.
